// File: rtl/pma_region_unit_if.sv
// Bus bundle for the PMA region unit: configuration port, lookup request
// channel, lookup response channel and the fault counter.
interface pma_region_unit_if #(
  parameter int NUM_REGIONS = 4,
  parameter int FAULT_CNT_W = 16
);
  localparam int IDX_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;

  logic                   cfg_we;
  logic [IDX_W-1:0]       cfg_idx;
  logic [1:0]             cfg_field;
  logic [31:0]            cfg_wdata;
  logic                   cfg_err;

  logic                   req_valid;
  logic                   req_ready;
  logic [31:0]            req_addr;
  logic [1:0]             req_type;

  logic                   rsp_valid;
  logic                   rsp_ready;
  logic                   rsp_hit;
  logic                   rsp_cacheable;
  logic                   rsp_fault;
  logic [IDX_W-1:0]       rsp_region;
  logic [FAULT_CNT_W-1:0] fault_count;

  modport master (
    output cfg_we, cfg_idx, cfg_field, cfg_wdata,
    output req_valid, req_addr, req_type, rsp_ready,
    input  cfg_err, req_ready, rsp_valid, rsp_hit, rsp_cacheable,
    input  rsp_fault, rsp_region, fault_count
  );

  modport slave (
    input  cfg_we, cfg_idx, cfg_field, cfg_wdata,
    input  req_valid, req_addr, req_type, rsp_ready,
    output cfg_err, req_ready, rsp_valid, rsp_hit, rsp_cacheable,
    output rsp_fault, rsp_region, fault_count
  );
endinterface

// File: rtl/pma_region_unit.sv
// PMA region unit: a small table of programmable [L,H] address regions with
// {lock, enable, X, W, C} attributes. Lookups are resolved to the lowest
// matching region and returned one cycle later over a valid/ready channel.
// Locked regions reject all further writes until reset.
module pma_region_unit #(
  parameter int         NUM_REGIONS  = 4,
  parameter logic [2:0] DEFAULT_ATTR = 3'b000,
  parameter int         FAULT_CNT_W  = 16
) (
  input logic              clk,
  input logic              rst,
  pma_region_unit_if.slave bus
);
  localparam int IDX_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;
  localparam logic [IDX_W:0] NUM_R = (IDX_W + 1)'(NUM_REGIONS);

  // Attribute bit positions inside attr_q
  localparam int A_LOCK = 4;
  localparam int A_EN   = 3;
  localparam int A_X    = 2;
  localparam int A_W    = 1;
  localparam int A_C    = 0;

  // Region table
  logic [31:0] lo_q   [NUM_REGIONS];
  logic [31:0] hi_q   [NUM_REGIONS];
  logic [4:0]  attr_q [NUM_REGIONS];

  // Configuration decode
  logic cfg_wr_s;
  logic cfg_locked_s;
  logic cfg_err_d;
  logic cfg_err_q;

  // Lookup result (combinational, against the pre-write table)
  logic             hit_d;
  logic [IDX_W-1:0] region_d;
  logic [2:0]       sel_attr_s;
  logic             fault_d;
  logic             cacheable_d;

  // Handshake and response registers
  logic             req_ready_s;
  logic             accept_s;
  logic             rsp_valid_q;
  logic             rsp_hit_q;
  logic             rsp_cacheable_q;
  logic             rsp_fault_q;
  logic [IDX_W-1:0] rsp_region_q;
  logic [FAULT_CNT_W-1:0] fault_cnt_q;

  // Enabled region containing addr, unsigned inclusive bounds; L > H never matches.
  function automatic logic region_match(input logic en, input logic [31:0] lo,
                                        input logic [31:0] hi, input logic [31:0] addr);
    return en && (addr >= lo) && (addr <= hi);
  endfunction

  assign req_ready_s = !rsp_valid_q || bus.rsp_ready;
  assign accept_s    = bus.req_valid && req_ready_s;

  // Decide whether the current config write is legal or must be rejected.
  always_comb begin
    cfg_wr_s     = 1'b0;
    cfg_err_d    = 1'b0;
    cfg_locked_s = 1'b0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      cfg_locked_s = cfg_locked_s | (attr_q[i][A_LOCK] & (bus.cfg_idx == IDX_W'(i)));
    end
    if (bus.cfg_we) begin
      if (({1'b0, bus.cfg_idx} >= NUM_R) || (bus.cfg_field == 2'd3) || cfg_locked_s) begin
        cfg_err_d = 1'b1;
      end else begin
        cfg_wr_s = 1'b1;
      end
    end else begin
      cfg_wr_s = 1'b0;
    end
  end

  // Region table update; a write with lock=1 lands together with its other attr bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGIONS; i++) begin
        lo_q[i]   <= 32'h0000_0000;
        hi_q[i]   <= 32'h0000_0000;
        attr_q[i] <= 5'b00000;
      end
    end else if (cfg_wr_s) begin
      for (int i = 0; i < NUM_REGIONS; i++) begin
        if (bus.cfg_idx == IDX_W'(i)) begin
          case (bus.cfg_field)
            2'd0:    lo_q[i]   <= bus.cfg_wdata;
            2'd1:    hi_q[i]   <= bus.cfg_wdata;
            2'd2:    attr_q[i] <= bus.cfg_wdata[4:0];
            default: attr_q[i] <= attr_q[i];
          endcase
        end
      end
    end
  end

  // Rejected-write pulse, one cycle after the offending write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= cfg_err_d;
    end
  end

  // Priority match (lowest index wins), then fault and cacheability from the selected attrs.
  always_comb begin
    hit_d      = 1'b0;
    region_d   = '0;
    sel_attr_s = DEFAULT_ATTR;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if (!hit_d && region_match(attr_q[i][A_EN], lo_q[i], hi_q[i], bus.req_addr)) begin
        hit_d      = 1'b1;
        region_d   = IDX_W'(i);
        sel_attr_s = attr_q[i][2:0];
      end else begin
        hit_d      = hit_d;
      end
    end
    case (bus.req_type)
      2'd0:    fault_d = !sel_attr_s[A_X];
      2'd1:    fault_d = 1'b0;
      2'd2:    fault_d = !sel_attr_s[A_W];
      default: fault_d = 1'b1;
    endcase
    cacheable_d = sel_attr_s[A_C] && !fault_d;
  end

  // Response register: load on accept, hold while stalled, drop after consumption.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q     <= 1'b0;
      rsp_hit_q       <= 1'b0;
      rsp_cacheable_q <= 1'b0;
      rsp_fault_q     <= 1'b0;
      rsp_region_q    <= '0;
    end else if (accept_s) begin
      rsp_valid_q     <= 1'b1;
      rsp_hit_q       <= hit_d;
      rsp_cacheable_q <= cacheable_d;
      rsp_fault_q     <= fault_d;
      rsp_region_q    <= region_d;
    end else if (bus.rsp_ready) begin
      rsp_valid_q     <= 1'b0;
    end else begin
      rsp_valid_q     <= rsp_valid_q;
    end
  end

  // Saturating count of accepted lookups that faulted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fault_cnt_q <= '0;
    end else if (accept_s && fault_d && (fault_cnt_q != {FAULT_CNT_W{1'b1}})) begin
      fault_cnt_q <= fault_cnt_q + FAULT_CNT_W'(1);
    end else begin
      fault_cnt_q <= fault_cnt_q;
    end
  end

  assign bus.req_ready     = req_ready_s;
  assign bus.cfg_err       = cfg_err_q;
  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_hit       = rsp_hit_q;
  assign bus.rsp_cacheable = rsp_cacheable_q;
  assign bus.rsp_fault     = rsp_fault_q;
  assign bus.rsp_region    = rsp_region_q;
  assign bus.fault_count   = fault_cnt_q;

endmodule

// File: doc/pma_region_unit.md
PMA_REGION_UNIT -- requirements
Module: pma_region_unit

Interface
REQ-001 SHALL have parameter NUM_REGIONS, default 4, number of programmable address regions (1-16).
REQ-002 SHALL have parameter DEFAULT_ATTR, default 3'b000, attributes {X,W,C} used when no region matches.
REQ-003 SHALL have parameter FAULT_CNT_W, default 16, width of the saturating fault counter.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-006 SHALL have port cfg_we  input  1  config write strobe.
REQ-007 SHALL have port cfg_idx  input  IDX_W  target region; IDX_W = max(1, clog2(NUM_REGIONS)).
REQ-008 SHALL have port cfg_field  input  2  0=L, 1=H, 2=attr, 3=reserved (write ignored).
REQ-009 SHALL have port cfg_wdata  input  32  write data; attr uses bits [4:0] = {lock, enable, X, W, C}.
REQ-010 SHALL have port cfg_err  output  1  one-cycle pulse: write rejected.
REQ-011 SHALL have port req_valid / req_ready  input / output  1 / 1  lookup handshake.
REQ-012 SHALL have port req_addr  input  32  lookup address.
REQ-013 SHALL have port req_type  input  2  0=fetch, 1=load, 2=store.
REQ-014 SHALL have port rsp_valid / rsp_ready  output / input  1 / 1  result handshake.
REQ-015 SHALL have port rsp_hit, rsp_cacheable, rsp_fault  output  1 each  lookup result.
REQ-016 SHALL have port rsp_region  output  IDX_W  matching region index, 0 when no hit.
REQ-017 SHALL have port fault_count  output  FAULT_CNT_W  number of faulted lookups.

Function
REQ-018 SHALL treat region i as a match when enable=1 and L <= req_addr <= H (unsigned, inclusive); L > H never matches.
REQ-019 SHALL resolve multiple matches to the lowest index.
REQ-020 SHALL use DEFAULT_ATTR with rsp_hit=0 when nothing matches.
REQ-021 SHALL assert rsp_fault when: fetch and X=0; store and W=0; or req_type=3. Loads never fault.
REQ-022 SHALL set rsp_cacheable = C of the selected attributes, or 0 when rsp_fault=1.
REQ-023 SHALL register the result: on req_valid && req_ready, drive rsp_* on the next cycle (latency 1).
REQ-024 SHALL drive req_ready = !rsp_valid || rsp_ready, giving full throughput back-to-back.
REQ-025 SHALL hold all rsp_* stable while rsp_valid && !rsp_ready.
REQ-026 SHALL clear rsp_valid after the accepting rsp_ready unless a new request is accepted in the same cycle.
REQ-027 SHALL apply a cfg write at the clock edge; a lookup accepted in the same cycle uses the pre-write table.
REQ-028 SHALL ignore any write to a region whose lock=1 and pulse cfg_err the next cycle; lock clears only on reset.
REQ-029 SHALL apply a write that sets lock=1 together with the rest of the attr fields in the same write.
REQ-030 SHALL ignore writes with cfg_idx >= NUM_REGIONS or cfg_field=3 and pulse cfg_err.
REQ-031 SHALL increment fault_count once per accepted faulting lookup and saturate at all-ones.

Reset
REQ-032 SHALL, while rst=1, clear all region L, H and attr fields (disabled, unlocked), plus rsp_valid, rsp_hit, rsp_cacheable, rsp_fault, rsp_region, cfg_err and fault_count.
REQ-033 SHALL discard an in-flight response on reset mid-operation; req_ready=1 in the first cycle after reset.

Verification
REQ-034 SHALL cover: region0 L=0x80000000 H=0x87FFFFFF attr=0x0F; fetch 0x80001000 -> next cycle rsp_hit=1, rsp_cacheable=1, rsp_fault=0, rsp_region=0.
REQ-035 SHALL cover: regions 0 and 1 overlapping at 0x88000000, region1 attr C=1; load 0x88000000 -> rsp_region=0.
REQ-036 SHALL cover: store to 0x60000000 with no match and DEFAULT_ATTR=0 -> rsp_hit=0, rsp_fault=1, fault_count goes from 0 to 1.
REQ-037 SHALL cover: lock region2, then write H=0xFFFFFFFF -> cfg_err pulses one cycle and region2 H is unchanged.
REQ-038 SHALL cover: rsp_ready held low for 3 cycles -> rsp_* stable and req_ready=0; rsp_ready then raised with a new request -> no bubble between responses.
REQ-039 SHALL cover: fault_count forced to 0xFFFF plus another fault -> fault_count stays 0xFFFF.
